// File: rtl/tick_period_meter.sv
// Measures the number of idle clock cycles between consecutive events on evt_in.
// Each captured spacing is reported on period with a one-cycle period_valid pulse.
`timescale 1ns/1ps
module tick_period_meter #(
    parameter int WIDTH       = 24,
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             evt_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             overflow,
    output logic             stalled,
    output logic             armed
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_MEASURE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic             e;

    // Saturating increment: the interval counter sticks at all-ones.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [SYNC_STAGES-1:0] sync_p0;
            logic                   sync_d_p1;

            // Synchronizer chain, then a delayed copy for rising-edge detection.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_p0   <= '0;
                    sync_d_p1 <= 1'b0;
                end else begin
                    sync_p0   <= {sync_p0[SYNC_STAGES-2:0], evt_in};
                    sync_d_p1 <= sync_p0[SYNC_STAGES-1];
                end
            end

            assign e = sync_p0[SYNC_STAGES-1] & ~sync_d_p1;
        end else begin : g_level
            assign e = evt_in;
        end
    endgenerate

    assign cnt_inc = sat_inc(cnt);

    // Measurement FSM; en low overrides everything, including a coincident event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            stalled      <= 1'b0;
            armed        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!en) begin
                state   <= S_IDLE;
                cnt     <= '0;
                stalled <= 1'b0;
                armed   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_ARMED;
                        cnt   <= '0;
                        armed <= 1'b1;
                    end
                    S_ARMED: begin
                        armed <= 1'b1;
                        if (e) begin
                            state <= S_MEASURE;
                            cnt   <= '0;
                        end
                    end
                    S_MEASURE: begin
                        armed <= 1'b1;
                        if (e) begin
                            period       <= cnt;
                            overflow     <= (cnt == CNT_MAX);
                            period_valid <= 1'b1;
                            cnt          <= '0;
                            stalled      <= 1'b0;
                        end else begin
                            cnt     <= cnt_inc;
                            stalled <= (cnt_inc == CNT_MAX);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
